cell_proc_driver: RTL and testbench

- Initiator side of the image-processor interface: drives pixelA, pixelB, userInput and opcode into the cell processor and collects processedPixel.
- Accepts one job command (opcode, user value, pixel-pair count), pairs two valid/ready pixel streams, and issues one operand pair per cycle.
- Buffers results in a small FIFO and returns them on a valid/ready result stream with backpressure.
- Sits between the image-fetch logic and the cell processor's internal port set.

---
 rtl/cell_proc_driver.sv | 146 ++++++++++++++
 tb/tb_cell_proc_driver.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_proc_driver.sv
// Initiator for the cell processor port: pairs two pixel streams, issues
// operand pairs under FIFO credit, and returns results with backpressure.
module cell_proc_driver #(
    parameter int PIXEL_W    = 8,
    parameter int OPCODE_W   = 4,
    parameter int PROC_LAT   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OPCODE_W-1:0] cmd_opcode,
    input  logic [PIXEL_W-1:0]  cmd_user,
    input  logic [CNT_W-1:0]    cmd_count,
    input  logic                a_valid,
    input  logic [PIXEL_W-1:0]  a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [PIXEL_W-1:0]  b_data,
    output logic                b_ready,
    output logic [PIXEL_W-1:0]  pixelA,
    output logic [PIXEL_W-1:0]  pixelB,
    output logic [PIXEL_W-1:0]  userInput,
    output logic [OPCODE_W-1:0] opcode,
    input  logic [PIXEL_W-1:0]  processedPixel,
    output logic                res_valid,
    output logic [PIXEL_W-1:0]  res_data,
    output logic                res_last,
    input  logic                res_ready,
    output logic                busy,
    output logic                done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } stateType;

    stateType state, nextState;

    logic [CNT_W-1:0]  remaining;
    logic [OW-1:0]     inflight;
    logic [OW-1:0]     fifoCount;
    logic [OW:0]       used;
    logic [PW-1:0]     wrPtr;
    logic [PW-1:0]     rdPtr;
    logic [PROC_LAT:0] tagVld;
    logic [PROC_LAT:0] tagLast;
    logic [PIXEL_W:0]  mem [FIFO_DEPTH];
    logic [PIXEL_W:0]  head;
    logic              issue;
    logic              wrEn;
    logic              popEn;

    // Credit covers both buffered and still-in-flight results
    assign used  = {1'b0, inflight} + {1'b0, fifoCount};
    assign issue = (state == RUN) & a_valid & b_valid
                 & (remaining != '0)
                 & (used < (OW+1)'(FIFO_DEPTH));

    assign wrEn      = tagVld[PROC_LAT];
    assign res_valid = (fifoCount != '0);
    assign popEn     = res_valid & res_ready;
    assign head      = mem[rdPtr];
    assign res_data  = res_valid ? head[PIXEL_W-1:0] : '0;
    assign res_last  = res_valid & head[PIXEL_W];

    assign a_ready   = issue;
    assign b_ready   = issue;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  if (cmd_valid)
                       nextState = (cmd_count == '0) ? FIN : RUN;
            RUN:   if (remaining == '0) nextState = DRAIN;
            DRAIN: if (popEn && head[PIXEL_W]) nextState = FIN;
            FIN:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            opcode    <= '0;
            userInput <= '0;
            pixelA    <= '0;
            pixelB    <= '0;
            tagVld    <= '0;
            tagLast   <= '0;
            inflight  <= '0;
            fifoCount <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && cmd_valid) begin
                opcode    <= cmd_opcode;
                userInput <= cmd_user;
                remaining <= cmd_count;
            end else if (issue) begin
                remaining <= remaining - CNT_W'(1);
            end
            if (issue) begin
                pixelA <= a_data;
                pixelB <= b_data;
            end
            tagVld[0]  <= issue;
            tagLast[0] <= issue & (remaining == CNT_W'(1));
            for (int i = 1; i <= PROC_LAT; i++) begin
                tagVld[i]  <= tagVld[i-1];
                tagLast[i] <= tagLast[i-1];
            end
            if (issue && !wrEn)
                inflight <= inflight + OW'(1);
            else if (!issue && wrEn)
                inflight <= inflight - OW'(1);
            if (wrEn && !popEn)
                fifoCount <= fifoCount + OW'(1);
            else if (!wrEn && popEn)
                fifoCount <= fifoCount - OW'(1);
            if (wrEn)
                wrPtr <= wrPtr + PW'(1);
            if (popEn)
                rdPtr <= rdPtr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn)
            mem[wrPtr] <= {tagLast[PROC_LAT], processedPixel};
    end

endmodule

// File: tb/tb_cell_proc_driver.sv
// Directed bench for cell_proc_driver with a registered adder standing
// in for the cell processor (PROC_LAT=1, FIFO_DEPTH=4).
module tb_cell_proc_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [7:0]  cmd_user;
    logic [15:0] cmd_count;
    logic        a_valid;
    logic [7:0]  a_data;
    logic        a_ready;
    logic        b_valid;
    logic [7:0]  b_data;
    logic        b_ready;
    logic [7:0]  pixelA;
    logic [7:0]  pixelB;
    logic [7:0]  userInput;
    logic [3:0]  opcode;
    logic [7:0]  processedPixel;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_last;
    logic        res_ready;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    logic [7:0] procQ;
    always @(posedge clk) procQ <= pixelA + pixelB;
    assign processedPixel = procQ;

    cell_proc_driver #(
        .PIXEL_W(8), .OPCODE_W(4), .PROC_LAT(1),
        .FIFO_DEPTH(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_user(cmd_user),
        .cmd_count(cmd_count),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .pixelA(pixelA), .pixelB(pixelB),
        .userInput(userInput), .opcode(opcode),
        .processedPixel(processedPixel),
        .res_valid(res_valid), .res_data(res_data),
        .res_last(res_last), .res_ready(res_ready),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expD;
        logic       expL;
    } vecType;

    vecType     vec [4];
    logic [7:0] aQ[$];
    logic [7:0] bQ[$];
    logic [7:0] gotD[$];
    logic       gotL[$];
    logic [7:0] expD[$];
    logic       expL[$];

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int issueCnt, doneCnt, splitErr, stableErr, busyRdyErr;
    int resSeen, accCnt, accCyc, firstIssue, firstRes;
    int firstDone, doneCyc;
    logic [3:0] firstDoneOp;
    logic [3:0] curOp;
    logic [7:0] curUser;
    bit bToggle = 0;
    bit holdCmd = 0;
    bit lastAReady;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic clearStats();
        issueCnt = 0; doneCnt = 0; splitErr = 0; stableErr = 0;
        busyRdyErr = 0; resSeen = 0; accCnt = 0; accCyc = -1;
        firstIssue = -1; firstRes = -1; firstDone = -1; doneCyc = -1;
        firstDoneOp = '0;
        gotD.delete(); gotL.delete(); expD.delete(); expL.delete();
    endtask

    task automatic drive();
        a_valid = (aQ.size() != 0);
        b_valid = (bQ.size() != 0) && (!bToggle || cyc[0]);
        a_data  = (aQ.size() != 0) ? aQ[0] : 8'h00;
        b_data  = (bQ.size() != 0) ? bQ[0] : 8'h00;
    endtask

    task automatic tick();
        bit aHs;
        bit acc;
        @(negedge clk);
        aHs = a_ready;
        acc = cmd_valid && cmd_ready;
        lastAReady = a_ready;
        if (a_ready != b_ready) splitErr++;
        if (a_ready && !(a_valid && b_valid)) splitErr++;
        if (a_ready) begin
            issueCnt++;
            if (firstIssue < 0) firstIssue = cyc;
        end
        if (res_valid) begin
            resSeen++;
            if (firstRes < 0) firstRes = cyc;
        end
        if (res_valid && res_ready) begin
            gotD.push_back(res_data);
            gotL.push_back(res_last);
        end
        if (done) begin
            doneCnt++;
            doneCyc = cyc;
            if (firstDone < 0) begin
                firstDone = cyc;
                firstDoneOp = opcode;
            end
        end
        if (busy && (opcode != curOp || userInput != curUser)) stableErr++;
        if (busy && cmd_ready) busyRdyErr++;
        @(posedge clk);
        #1;
        cyc++;
        if (aHs) begin
            aQ.delete(0);
            bQ.delete(0);
        end
        if (acc) begin
            accCnt++;
            accCyc = cyc;
            curOp = cmd_opcode;
            curUser = cmd_user;
            if (!holdCmd) cmd_valid = 1'b0;
        end
        drive();
    endtask

    task automatic startCmd(input logic [3:0] op, input logic [7:0] usr,
                            input logic [15:0] cnt);
        cmd_opcode = op;
        cmd_user = usr;
        cmd_count = cnt;
        cmd_valid = 1'b1;
        tick();
    endtask

    task automatic waitDone(input int target, input int budget);
        int n;
        n = 0;
        while (doneCnt < target && n < budget) begin
            tick();
            n++;
        end
        if (doneCnt < target) chk("done_timeout", doneCnt, target);
    endtask

    task automatic addPair(input logic [7:0] a, input logic [7:0] b,
                           input logic last);
        aQ.push_back(a);
        bQ.push_back(b);
        expD.push_back(a + b);
        expL.push_back(last);
    endtask

    function automatic int dataErrs();
        int e;
        e = 0;
        for (int i = 0; i < expD.size(); i++) begin
            if (i >= gotD.size()) e++;
            else if (gotD[i] != expD[i] || gotL[i] != expL[i]) e++;
        end
        return e;
    endfunction

    initial begin
        vec[0] = '{8'h01, 8'h02, 8'h03, 1'b0};
        vec[1] = '{8'h05, 8'h05, 8'h0A, 1'b0};
        vec[2] = '{8'hFF, 8'h02, 8'h01, 1'b0};
        vec[3] = '{8'h07, 8'h00, 8'h07, 1'b1};

        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_opcode = '0;
        cmd_user = '0;
        cmd_count = '0;
        res_ready = 1'b0;
        curOp = '0;
        curUser = '0;
        clearStats();
        drive();
        repeat (2) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_outs", {a_ready, b_ready, done, pixelA, pixelB, opcode}, 0);
        rst = 1'b1;
        tick();

        // Basic job, table-driven
        clearStats();
        for (int i = 0; i < 4; i++) begin
            aQ.push_back(vec[i].a);
            bQ.push_back(vec[i].b);
        end
        drive();
        res_ready = 1'b1;
        startCmd(4'd3, 8'h10, 16'd4);
        waitDone(1, 40);
        chk("t2_count", gotD.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_data%0d", i),
                (i < gotD.size()) ? int'(gotD[i]) : -1, vec[i].expD);
            chk($sformatf("t2_last%0d", i),
                (i < gotL.size()) ? int'(gotL[i]) : -1, vec[i].expL);
        end
        chk("t2_latency", firstRes - firstIssue, 3);
        chk("t2_stable", stableErr, 0);
        chk("t2_done", doneCnt, 1);
        chk("t2_busy_after", busy, 0);
        chk("t2_opcode_hold", opcode, 3);
        chk("t2_user_hold", userInput, 8'h10);

        // Backpressure fills the FIFO and stops issue
        clearStats();
        for (int i = 0; i < 10; i++)
            addPair(8'(i * 7 + 1), 8'(8'h30 + i), i == 9);
        drive();
        res_ready = 1'b0;
        startCmd(4'd2, 8'h44, 16'd10);
        repeat (12) tick();
        chk("t3_issue_stall", issueCnt, 4);
        chk("t3_a_ready_low", lastAReady, 0);
        chk("t3_no_pop", gotD.size(), 0);
        res_ready = 1'b1;
        waitDone(1, 80);
        chk("t3_count", gotD.size(), 10);
        chk("t3_data_errs", dataErrs(), 0);
        chk("t3_done", doneCnt, 1);

        // Stream B stalls every other cycle
        clearStats();
        bToggle = 1'b1;
        for (int i = 0; i < 6; i++)
            addPair(8'(8'h10 * i + 3), 8'(8'hA0 - i), i == 5);
        drive();
        startCmd(4'd6, 8'h5A, 16'd6);
        waitDone(1, 80);
        bToggle = 1'b0;
        chk("t4_split", splitErr, 0);
        chk("t4_issues", issueCnt, 6);
        chk("t4_count", gotD.size(), 6);
        chk("t4_data_errs", dataErrs(), 0);

        // Zero-length job
        clearStats();
        aQ.push_back(8'h11);
        bQ.push_back(8'h22);
        aQ.push_back(8'h33);
        bQ.push_back(8'h44);
        drive();
        startCmd(4'd7, 8'h55, 16'd0);
        waitDone(1, 5);
        chk("t5_done_quick", int'(doneCyc - accCyc <= 1 && doneCyc >= accCyc), 1);
        chk("t5_no_issue", issueCnt, 0);
        chk("t5_no_result", resSeen, 0);
        chk("t5_streams_kept", aQ.size(), 2);
        aQ.delete();
        bQ.delete();
        tick();

        // Back-to-back commands, second held during the first job
        clearStats();
        addPair(8'h01, 8'h01, 1'b0);
        addPair(8'h02, 8'h02, 1'b0);
        addPair(8'h03, 8'h03, 1'b1);
        addPair(8'h04, 8'h04, 1'b0);
        addPair(8'h05, 8'h05, 1'b1);
        drive();
        holdCmd = 1'b1;
        startCmd(4'd5, 8'h22, 16'd3);
        cmd_opcode = 4'd9;
        cmd_user = 8'h33;
        cmd_count = 16'd2;
        for (int n = 0; n < 60 && accCnt < 2; n++) tick();
        cmd_valid = 1'b0;
        holdCmd = 1'b0;
        chk("t6_accepts", accCnt, 2);
        chk("t6_accept_after_done", int'(accCyc > firstDone && firstDone >= 0), 1);
        chk("t6_op_at_done1", firstDoneOp, 5);
        waitDone(2, 60);
        chk("t6_busy_ready", busyRdyErr, 0);
        chk("t6_stable", stableErr, 0);
        chk("t6_count", gotD.size(), 5);
        chk("t6_job2_first_last", (gotL.size() > 3) ? int'(gotL[3]) : -1, 0);
        chk("t6_data_errs", dataErrs(), 0);
        chk("t6_opcode2", opcode, 9);

        // Reset in the middle of a backpressured job
        clearStats();
        for (int i = 0; i < 6; i++)
            addPair(8'(8'h20 + i), 8'(i), i == 5);
        drive();
        res_ready = 1'b0;
        startCmd(4'd4, 8'h66, 16'd6);
        for (int n = 0; n < 20 && resSeen == 0; n++) tick();
        chk("t1_buffered", res_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t1_res_valid", res_valid, 0);
        chk("t1_cmd_ready", cmd_ready, 1);
        chk("t1_outs",
            {busy, done, a_ready, b_ready, res_last, res_data,
             pixelA, pixelB, userInput, opcode}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        aQ.delete();
        bQ.delete();
        clearStats();
        drive();
        res_ready = 1'b1;
        repeat (8) tick();
        chk("t1_no_done", doneCnt, 0);
        chk("t1_no_stale", resSeen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
